match_sequencer: RTL and testbench
==================================

# match_sequencer

Game-level controller for the Connect-4 Pop design: sequences each game (board clear, turn alternation, win/draw detection, turn timeout) and drives the per-player score counter. It converts board-checker win levels into clean, non-overlapping score strobes. It never raises both strobes in the same cycle, so the counter's edge detectors register exactly one point per game. It sits between the board/win-checker logic and the score counter.

## Interface
- PULSE_LEN, 2: cycles a score strobe is held high (≥1).
- TO_W, 28: width of the turn-timeout counter.
- TURN_TIMEOUT, 28'd200_000_000: cycles without a move before the turn is forfeited; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- new_game  in  1  single-cycle pulse, debounced upstream.
- clear_scores  in  1  single-cycle pulse; request to zero both scores.
- move_done  in  1  single-cycle pulse from the board when a drop or pop commits.
- win_p1, win_p2, draw  in  1 each  win-checker levels, evaluated on the current board.
- turn  out  1  player to move: 0 = P1, 1 = P2.
- board_enable  out  1  high only in PLAY; the board accepts moves only then.
- board_clear  out  1  one-cycle board wipe.
- score_p1, score_p2  out  1 each  score strobes to the counter.
- score_clear  out  1  one-cycle synchronous clear to the counter.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; holds the result of the last game.
- state  out  3  FSM state code for debug.

## Operation
- States and codes: IDLE 0, CLEAR 1, PLAY 2, SCORE 3, GAP 4, OVER 5.
- IDLE: on new_game, go to CLEAR.
- CLEAR: lasts 1 cycle.
  - Asserts board_clear and sets winner = 00.
  - Loads turn from the starter register, then toggles starter, so the opening player alternates game to game.
  - Next state is PLAY.
- PLAY, evaluated each cycle with priority new_game > win > draw > move_done > timeout:
  - new_game: abandon the game, go to CLEAR. No score change.
  - win_p1 xor win_p2: that player wins; go to SCORE.
  - win_p1 and win_p2 together (a pop can complete lines for both): last_mover wins; go to SCORE.
  - draw with no win: winner = 11; go to OVER.
  - move_done: last_mover <= turn, turn toggles, timeout counter clears.
  - Timeout counter reaches TURN_TIMEOUT − 1: turn toggles and the counter clears. last_mover is not changed.
- SCORE: strobe for the winner is high for exactly PULSE_LEN cycles; winner is set on entry. Then go to GAP.
- GAP: both strobes low for 1 cycle; go to OVER. This guarantees a low sample between strobes.
- OVER: board_enable = 0; on new_game, go to CLEAR.
- Handling of clear_scores:
  - Pulse sets a pending flag.
  - score_clear fires on the first cycle the FSM is not in SCORE or GAP, then the flag clears.
  - A strobe in progress is therefore never cancelled by the clear.
  - A repeat pulse while pending is absorbed.
- Timeout counter: TO_W bits, runs only in PLAY, saturates and never wraps. It is held at 0 when TURN_TIMEOUT = 0.
- Invariants: score_p1 & score_p2 is never 1; board_enable is 1 only in PLAY.

## Timing
- Reset values: state IDLE, turn 0, starter 0, last_mover 0, winner 00, pending 0, timeout counter 0, all other outputs 0.
- Outputs are registered and change one cycle after the triggering input is sampled.
- Win sampled at edge N (state PLAY): SCORE from N+1 with the strobe high over N+1 .. N+PULSE_LEN, GAP at N+PULSE_LEN+1, OVER after that.
- new_game at edge N: board_clear high at N+1, board_enable high at N+2.
- move_done and win in the same cycle: win wins, turn does not toggle, last_mover is not updated.
- Reset deasserted mid-game: the FSM restarts in IDLE; score counter contents are untouched.

## Test plan
- Reset, new_game, then win_p1 high one cycle → board_clear at +1, then score_p1 high for 2 cycles, winner = 01, state 5, score_p2 stays 0.
- Moves with turn = 0 then move_done; next cycle win_p1 = win_p2 = 1 → last_mover = 0, so score_p1 strobes and winner = 01.
- Three consecutive new_game → CLEAR sequences → turn after CLEAR is 0, 1, 0.
- TURN_TIMEOUT = 10, no move_done → turn toggles every 10 cycles in PLAY; with TURN_TIMEOUT = 0 it never toggles.
- clear_scores on the second cycle of SCORE → score_clear asserted on the first OVER cycle; the strobe is complete and never overlaps the clear.
- draw in PLAY → winner = 11, no strobe; new_game in PLAY → CLEAR, no strobe, winner = 00.

Source files
------------

// File: rtl/match_sequencer.sv
// Game-level controller for Connect-4 Pop: sequences each game, alternates turns,
// and turns win-checker levels into clean, non-overlapping score strobes.
module match_sequencer #(
    parameter int unsigned     PULSE_LEN    = 2,
    parameter int unsigned     TO_W         = 28,
    parameter logic [TO_W-1:0] TURN_TIMEOUT = TO_W'(200_000_000)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       clear_scores,
    input  logic       move_done,
    input  logic       win_p1,
    input  logic       win_p2,
    input  logic       draw,
    output logic       turn,
    output logic       board_enable,
    output logic       board_clear,
    output logic       score_p1,
    output logic       score_p2,
    output logic       score_clear,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int unsigned     PCW        = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCW-1:0]  PULSE_LAST = PCW'(PULSE_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TURN_TIMEOUT - TO_W'(1);
    localparam logic            TO_EN      = (TURN_TIMEOUT != '0);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_SCORE = 3'd3,
        ST_GAP   = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            turn_q, turn_d;
    logic            starter_q, starter_d;
    logic            last_mover_q, last_mover_d;
    logic [1:0]      winner_q, winner_d;
    logic            pending_q, pending_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic            board_enable_q, board_enable_d;
    logic            board_clear_q, board_clear_d;
    logic            score_p1_q, score_p1_d;
    logic            score_p2_q, score_p2_d;
    logic            score_clear_q, score_clear_d;
    logic            pending_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            turn_q         <= 1'b0;
            starter_q      <= 1'b0;
            last_mover_q   <= 1'b0;
            winner_q       <= WIN_NONE;
            pending_q      <= 1'b0;
            to_cnt_q       <= '0;
            pcnt_q         <= '0;
            board_enable_q <= 1'b0;
            board_clear_q  <= 1'b0;
            score_p1_q     <= 1'b0;
            score_p2_q     <= 1'b0;
            score_clear_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            turn_q         <= turn_d;
            starter_q      <= starter_d;
            last_mover_q   <= last_mover_d;
            winner_q       <= winner_d;
            pending_q      <= pending_d;
            to_cnt_q       <= to_cnt_d;
            pcnt_q         <= pcnt_d;
            board_enable_q <= board_enable_d;
            board_clear_q  <= board_clear_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            score_clear_q  <= score_clear_d;
        end
    end

    // Outputs are registered from the next state, so they track the state one cycle after sampling.
    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        starter_d    = starter_q;
        last_mover_d = last_mover_q;
        winner_d     = winner_q;
        to_cnt_d     = to_cnt_q;
        pcnt_d       = pcnt_q;
        pending_eff  = pending_q | clear_scores;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (new_game) state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                if (new_game) begin
                    state_d = ST_CLEAR;
                end else if (win_p1 || win_p2) begin
                    state_d = ST_SCORE;
                    pcnt_d  = '0;
                    if (win_p1 && win_p2) begin
                        winner_d = last_mover_q ? WIN_P2 : WIN_P1;
                    end else begin
                        winner_d = win_p1 ? WIN_P1 : WIN_P2;
                    end
                end else if (draw) begin
                    state_d  = ST_OVER;
                    winner_d = WIN_DRAW;
                end else if (move_done) begin
                    last_mover_d = turn_q;
                    turn_d       = ~turn_q;
                    to_cnt_d     = '0;
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    turn_d   = ~turn_q;
                    to_cnt_d = '0;
                end else if (TO_EN && (to_cnt_q != '1)) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_SCORE: begin
                if (pcnt_q == PULSE_LAST) begin
                    state_d = ST_GAP;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
            ST_GAP:  state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase

        // CLEAR is always entered from another state, so this runs once per game start.
        if (state_d == ST_CLEAR) begin
            winner_d  = WIN_NONE;
            turn_d    = starter_q;
            starter_d = ~starter_q;
        end

        if (state_d != ST_PLAY) to_cnt_d = '0;

        // Hold a score clear off until any strobe and its trailing gap are done.
        score_clear_d  = pending_eff && (state_d != ST_SCORE) && (state_d != ST_GAP);
        pending_d      = pending_eff && !score_clear_d;
        board_clear_d  = (state_d == ST_CLEAR);
        board_enable_d = (state_d == ST_PLAY);
        score_p1_d     = (state_d == ST_SCORE) && (winner_d == WIN_P1);
        score_p2_d     = (state_d == ST_SCORE) && (winner_d == WIN_P2);
    end

    assign turn         = turn_q;
    assign board_enable = board_enable_q;
    assign board_clear  = board_clear_q;
    assign score_p1     = score_p1_q;
    assign score_p2     = score_p2_q;
    assign score_clear  = score_clear_q;
    assign winner       = winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed scoreboard bench for match_sequencer: expected output vectors are queued
// with each stimulus step and popped/checked one cycle later.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0, clear_scores = 1'b0, move_done = 1'b0;
    logic       win_p1 = 1'b0, win_p2 = 1'b0, draw = 1'b0;
    logic       turn, board_enable, board_clear, score_p1, score_p2, score_clear;
    logic [1:0] winner;
    logic [2:0] state;
    logic       turn0, board_enable0, board_clear0, score_p10, score_p20, score_clear0;
    logic [1:0] winner0;
    logic [2:0] state0;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_NG   = 6'b100000;
    localparam logic [5:0] I_CS   = 6'b010000;
    localparam logic [5:0] I_MD   = 6'b001000;
    localparam logic [5:0] I_W1   = 6'b000100;
    localparam logic [5:0] I_W2   = 6'b000010;
    localparam logic [5:0] I_DR   = 6'b000001;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_BE   = 5'b10000;
    localparam logic [4:0] F_BC   = 5'b01000;
    localparam logic [4:0] F_P1   = 5'b00100;
    localparam logic [4:0] F_P2   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00001;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb_q[$];

    logic [10:0] obs;
    assign obs = {state, turn, winner, board_enable, board_clear, score_p1, score_p2, score_clear};

    always #5 clk = ~clk;

    match_sequencer #(.PULSE_LEN(2), .TO_W(28), .TURN_TIMEOUT(28'd10)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .clear_scores(clear_scores),
        .move_done(move_done), .win_p1(win_p1), .win_p2(win_p2), .draw(draw),
        .turn(turn), .board_enable(board_enable), .board_clear(board_clear),
        .score_p1(score_p1), .score_p2(score_p2), .score_clear(score_clear),
        .winner(winner), .state(state)
    );

    match_sequencer #(.PULSE_LEN(2), .TO_W(28), .TURN_TIMEOUT(28'd0)) dut_noto (
        .clk(clk), .reset(reset), .new_game(new_game), .clear_scores(clear_scores),
        .move_done(move_done), .win_p1(win_p1), .win_p2(win_p2), .draw(draw),
        .turn(turn0), .board_enable(board_enable0), .board_clear(board_clear0),
        .score_p1(score_p10), .score_p2(score_p20), .score_clear(score_clear0),
        .winner(winner0), .state(state0)
    );

    task automatic push_exp(input logic [2:0] st, input logic tn, input logic [1:0] wn,
                            input logic [4:0] fl, input string tag);
        exp_t e;
        e.tag = tag;
        e.exp = {st, tn, wn, fl};
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        assert (obs === e.exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b ({state,turn,winner,be,bc,p1,p2,sc})",
                   e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input logic [5:0] in, input logic [2:0] st, input logic tn,
                        input logic [1:0] wn, input logic [4:0] fl, input string tag);
        {new_game, clear_scores, move_done, win_p1, win_p2, draw} = in;
        push_exp(st, tn, wn, fl, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_noto_turn(input logic exp_turn, input string tag);
        n_cmp++;
        assert (turn0 === exp_turn) else begin
            n_err++;
            $error("FAIL %s: observed turn %b required %b (timeout disabled)", tag, turn0, exp_turn);
        end
    endtask

    initial begin
        logic tn;

        #2;
        push_exp(3'd0, 1'b0, 2'b00, F_NONE, "reset_state");
        check_out();
        #10;
        reset = 1'b1;

        // Game 1: plain P1 win, starter 0
        step(I_NG,    3'd1, 1'b0, 2'b00, F_BC,   "g1_clear");
        step(I_NONE,  3'd2, 1'b0, 2'b00, F_BE,   "g1_play");
        step(I_W1,    3'd3, 1'b0, 2'b01, F_P1,   "g1_score0");
        step(I_NONE,  3'd3, 1'b0, 2'b01, F_P1,   "g1_score1");
        step(I_NONE,  3'd4, 1'b0, 2'b01, F_NONE, "g1_gap");
        step(I_NONE,  3'd5, 1'b0, 2'b01, F_NONE, "g1_over");

        // Game 2: starter 1, double win after P1 moved last
        step(I_NG,    3'd1, 1'b1, 2'b00, F_BC,   "g2_clear");
        step(I_NONE,  3'd2, 1'b1, 2'b00, F_BE,   "g2_play");
        step(I_MD,    3'd2, 1'b0, 2'b00, F_BE,   "g2_move_p2");
        step(I_MD,    3'd2, 1'b1, 2'b00, F_BE,   "g2_move_p1");
        step(I_W1 | I_W2, 3'd3, 1'b1, 2'b01, F_P1, "g2_both_lastp1");
        step(I_NONE,  3'd3, 1'b1, 2'b01, F_P1,   "g2_score1");
        step(I_NONE,  3'd4, 1'b1, 2'b01, F_NONE, "g2_gap");
        step(I_NONE,  3'd5, 1'b1, 2'b01, F_NONE, "g2_over");

        // Game 3: double win with P2 last mover, move_done in the same cycle is ignored
        step(I_NG,    3'd1, 1'b0, 2'b00, F_BC,   "g3_clear");
        step(I_NONE,  3'd2, 1'b0, 2'b00, F_BE,   "g3_play");
        step(I_MD,    3'd2, 1'b1, 2'b00, F_BE,   "g3_move_p1");
        step(I_MD,    3'd2, 1'b0, 2'b00, F_BE,   "g3_move_p2");
        step(I_MD | I_W1 | I_W2, 3'd3, 1'b0, 2'b10, F_P2, "g3_both_lastp2");
        step(I_NONE,  3'd3, 1'b0, 2'b10, F_P2,   "g3_score1");
        step(I_CS,    3'd4, 1'b0, 2'b10, F_NONE, "g3_gap_clr_held");
        step(I_NONE,  3'd5, 1'b0, 2'b10, F_SC,   "g3_over_clr");
        step(I_NONE,  3'd5, 1'b0, 2'b10, F_NONE, "g3_over_clr_done");
        step(I_CS,    3'd5, 1'b0, 2'b10, F_SC,   "over_clr_direct");
        step(I_NONE,  3'd5, 1'b0, 2'b10, F_NONE, "over_clr_direct_done");

        // Game 4: draw
        step(I_NG,    3'd1, 1'b1, 2'b00, F_BC,   "g4_clear");
        step(I_NONE,  3'd2, 1'b1, 2'b00, F_BE,   "g4_play");
        step(I_DR,    3'd5, 1'b1, 2'b11, F_NONE, "g4_draw");
        step(I_NONE,  3'd5, 1'b1, 2'b11, F_NONE, "g4_draw_hold");

        // Game 5: abandoned, then restarted game runs into turn timeouts
        step(I_NG,    3'd1, 1'b0, 2'b00, F_BC,   "g5_clear");
        step(I_NONE,  3'd2, 1'b0, 2'b00, F_BE,   "g5_play");
        step(I_NG,    3'd1, 1'b1, 2'b00, F_BC,   "g5_abandon");
        step(I_NONE,  3'd2, 1'b1, 2'b00, F_BE,   "g6_play");
        for (int k = 1; k <= 25; k++) begin
            tn = ((k / 10) % 2 == 1) ? 1'b0 : 1'b1;
            step(I_NONE, 3'd2, tn, 2'b00, F_BE, "timeout_idle");
            check_noto_turn(1'b1, "noto_idle");
        end
        step(I_MD,    3'd2, 1'b0, 2'b00, F_BE,   "timeout_move");
        check_noto_turn(1'b0, "noto_move");
        for (int k = 1; k <= 9; k++) begin
            step(I_NONE, 3'd2, 1'b0, 2'b00, F_BE, "timeout_after_move");
            check_noto_turn(1'b0, "noto_after_move");
        end
        step(I_NONE,  3'd2, 1'b1, 2'b00, F_BE,   "timeout_expire");
        check_noto_turn(1'b0, "noto_expire");

        // Asynchronous reset mid-game
        reset = 1'b0;
        #2;
        push_exp(3'd0, 1'b0, 2'b00, F_NONE, "async_reset");
        check_out();
        #2;
        reset = 1'b1;
        step(I_NONE,  3'd0, 1'b0, 2'b00, F_NONE, "post_reset_idle");
        step(I_NG,    3'd1, 1'b0, 2'b00, F_BC,   "post_reset_clear");
        step(I_NONE,  3'd2, 1'b0, 2'b00, F_BE,   "post_reset_play");
        {new_game, clear_scores, move_done, win_p1, win_p2, draw} = I_NONE;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
